led_digit_buffer: RTL and testbench

LED_DIGIT_BUFFER -- requirements
Module: led_digit_buffer

---
 rtl/led_digit_buffer_if.sv | 34 +++
 rtl/led_digit_buffer.sv | 153 +++++++++++++++
 tb/tb_led_digit_buffer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_digit_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : led_digit_buffer_if
// Purpose  : Host-side write/shift/clear bus and scan outputs of led_digit_buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface led_digit_buffer_if;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic [2:0] i_wr_addr;
  logic [4:0] i_wr_data;
  logic       i_shift_valid;
  logic [4:0] i_shift_data;
  logic       i_clear;
  logic [7:0] i_blink_mask;
  logic       o_busy;
  logic [2:0] o_cs_pointer;
  logic [4:0] o_dig_ctrl;
  logic       o_blank;
  logic       o_scan_tick;

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_shift_valid, i_shift_data,
           i_clear, i_blink_mask,
    input  o_wr_ready, o_busy, o_cs_pointer, o_dig_ctrl, o_blank, o_scan_tick
  );

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_shift_valid, i_shift_data,
           i_clear, i_blink_mask,
    output o_wr_ready, o_busy, o_cs_pointer, o_dig_ctrl, o_blank, o_scan_tick
  );
endinterface
`default_nettype wire

// File: rtl/led_digit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : led_digit_buffer
// Purpose  : 8 x 5-bit digit store with random write, shift-in, clear sweep and
//            a free-running scan pointer. Optional blinking via LED_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_digit_buffer #(
  parameter int F_CLK       = 50000000,
  parameter int F_SCAN      = 1000,
  parameter int BLINK_TICKS = 500
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst,
  led_digit_buffer_if.slave   bus
);

  localparam int DIV = F_CLK / F_SCAN;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    clr_idx_q, clr_idx_d;
  logic [4:0]    dig_q, dig_d;
  logic          busy_q, busy_d;
  logic [4:0]    mem_q [8];
  logic [4:0]    mem_d [8];
  logic          wr_ready;

  assign wr_ready = (state_q == S_IDLE) & ~bus.i_shift_valid & ~bus.i_clear & ~i_rst;

  always_comb begin
    presc_d = (presc_q == DIV_LAST) ? '0 : presc_q + PW'(1);
    // Registered tick lines up exactly with the cycle in which the count is DIV-1.
    tick_d  = (presc_d == DIV_LAST);
    ptr_d   = tick_q ? ptr_q + 3'd1 : ptr_q;
    dig_d   = mem_q[ptr_q];
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_d     = mem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_clear) begin
          state_d   = S_CLEAR;
          clr_idx_d = 3'd0;
        end else if (bus.i_shift_valid) begin
          for (int k = 7; k > 0; k--) begin
            mem_d[k] = mem_q[k-1];
          end
          mem_d[0] = bus.i_shift_data;
        end else if (bus.i_wr_valid && wr_ready) begin
          mem_d[bus.i_wr_addr] = bus.i_wr_data;
        end
      end
      S_CLEAR: begin
        mem_d[clr_idx_q] = 5'h00;
        clr_idx_d        = clr_idx_q + 3'd1;
        if (clr_idx_q == 3'd7) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      ptr_q     <= 3'd0;
      clr_idx_q <= 3'd0;
      dig_q     <= 5'h00;
      busy_q    <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        mem_q[k] <= 5'h00;
      end
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      ptr_q     <= ptr_d;
      clr_idx_q <= clr_idx_d;
      dig_q     <= dig_d;
      busy_q    <= busy_d;
      for (int k = 0; k < 8; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

`ifdef LED_BLINK_EN
  localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_on_q, phase_on_d;
  logic          blank_q, blank_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;
    if (tick_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    // Sampled from the same pointer as dig_d so blank and digit stay paired.
    blank_d = bus.i_blink_mask[ptr_q] & ~phase_on_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_on_q  <= phase_on_d;
      blank_q     <= blank_d;
    end
  end

  assign bus.o_blank = blank_q;
`else
  logic unused_blink;
  assign unused_blink = ^{bus.i_blink_mask, BLINK_TICKS[0]};
  assign bus.o_blank  = 1'b0;
`endif

  assign bus.o_wr_ready   = wr_ready;
  assign bus.o_busy       = busy_q;
  assign bus.o_cs_pointer = ptr_q;
  assign bus.o_dig_ctrl   = dig_q;
  assign bus.o_scan_tick  = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_digit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_digit_buffer
// Purpose  : Directed self-checking bench for led_digit_buffer (DIV = 8, BLINK_TICKS = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_digit_buffer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] model [8];

  always #5 clk = ~clk;

  led_digit_buffer_if bus_if ();

  led_digit_buffer #(
    .F_CLK       (8),
    .F_SCAN      (1),
    .BLINK_TICKS (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for the pointer to reach pos, then checks the digit one cycle later.
  task automatic check_pos(input int pos, input logic [4:0] exp, input string tag);
    int n = 0;
    while (bus_if.o_cs_pointer !== 3'(pos) && n < 80) begin
      tick_n(1);
      n++;
    end
    if (n >= 80) begin
      chk({tag, "_timeout"}, 32'(bus_if.o_cs_pointer), 32'(pos));
    end else begin
      tick_n(1);
      chk(tag, 32'(bus_if.o_dig_ctrl), 32'(exp));
    end
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < 8; p++) begin
      check_pos(p, model[p], $sformatf("%s_pos%0d", tag, p));
    end
  endtask

  task automatic model_shift(input logic [4:0] d);
    for (int k = 7; k > 0; k--) begin
      model[k] = model[k-1];
    end
    model[0] = d;
  endtask

  task automatic blink_run(input logic [7:0] mask, input string tag);
    logic e;
    int   j;
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    bus_if.i_blink_mask = mask;
    for (int k = 0; k < 64; k++) begin
      e = 1'b0;
`ifdef LED_BLINK_EN
      if (k >= 1) begin
        j = k - 1;
        e = mask[(j / 8) % 8] & ((j / 16) % 2 == 1);
      end
`else
      j = k;
`endif
      chk($sformatf("%s_blank_c%0d_j%0d", tag, k, j), 32'(bus_if.o_blank), 32'(e));
      tick_n(1);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    bus_if.i_wr_valid    = 1'b0;
    bus_if.i_wr_addr     = 3'd0;
    bus_if.i_wr_data     = 5'h00;
    bus_if.i_shift_valid = 1'b0;
    bus_if.i_shift_data  = 5'h00;
    bus_if.i_clear       = 1'b0;
    bus_if.i_blink_mask  = 8'h00;
    for (int k = 0; k < 8; k++) model[k] = 5'h00;

    // Reset state
    tick_n(3);
    chk("rst_ptr",   32'(bus_if.o_cs_pointer), 32'd0);
    chk("rst_dig",   32'(bus_if.o_dig_ctrl),   32'h00);
    chk("rst_tick",  32'(bus_if.o_scan_tick),  32'd0);
    chk("rst_busy",  32'(bus_if.o_busy),       32'd0);
    chk("rst_blank", 32'(bus_if.o_blank),      32'd0);
    chk("rst_ready", 32'(bus_if.o_wr_ready),   32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(bus_if.o_wr_ready), 32'd1);

    // Free-running scan: tick on every 8th cycle, pointer 0..7 and wrap
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("scan_tick_c%0d", k), 32'(bus_if.o_scan_tick),  32'(k % 8 == 7));
      chk($sformatf("scan_ptr_c%0d", k),  32'(bus_if.o_cs_pointer), 32'((k / 8) % 8));
      chk($sformatf("scan_dig_c%0d", k),  32'(bus_if.o_dig_ctrl),   32'h00);
      tick_n(1);
    end
    chk("scan_wrap_ptr", 32'(bus_if.o_cs_pointer), 32'd0);

    // Random write
    bus_if.i_wr_valid = 1'b1;
    bus_if.i_wr_addr  = 3'd3;
    bus_if.i_wr_data  = 5'h1A;
    #1;
    chk("wr_ready", 32'(bus_if.o_wr_ready), 32'd1);
    tick_n(1);
    bus_if.i_wr_valid = 1'b0;
    model[3] = 5'h1A;
    check_pos(3, 5'h1A, "wr_a3");
    check_pos(4, 5'h00, "wr_a4");

    // Shift in three values
    for (int i = 1; i <= 3; i++) begin
      bus_if.i_shift_valid = 1'b1;
      bus_if.i_shift_data  = 5'(i);
      #1;
      chk($sformatf("shift_ready_%0d", i), 32'(bus_if.o_wr_ready), 32'd0);
      tick_n(1);
      model_shift(5'(i));
    end
    bus_if.i_shift_valid = 1'b0;
    check_pos(0, 5'h03, "shift3_p0");
    check_pos(1, 5'h02, "shift3_p1");
    check_pos(2, 5'h01, "shift3_p2");
    check_pos(6, 5'h1A, "shift3_p6");

    // Six more shifts: ninth value pushes the first one out
    for (int i = 4; i <= 9; i++) begin
      bus_if.i_shift_valid = 1'b1;
      bus_if.i_shift_data  = 5'(i);
      tick_n(1);
      model_shift(5'(i));
    end
    bus_if.i_shift_valid = 1'b0;
    check_pos(7, 5'h02, "shift9_p7");
    check_all("shift9");

    // Shift and write in the same cycle: shift wins, write waits a cycle
    bus_if.i_shift_valid = 1'b1;
    bus_if.i_shift_data  = 5'h11;
    bus_if.i_wr_valid    = 1'b1;
    bus_if.i_wr_addr     = 3'd5;
    bus_if.i_wr_data     = 5'h15;
    #1;
    chk("sw_ready_lo", 32'(bus_if.o_wr_ready), 32'd0);
    tick_n(1);
    model_shift(5'h11);
    bus_if.i_shift_valid = 1'b0;
    #1;
    chk("sw_ready_hi", 32'(bus_if.o_wr_ready), 32'd1);
    tick_n(1);
    bus_if.i_wr_valid = 1'b0;
    model[5] = 5'h15;
    check_pos(5, 5'h15, "sw_p5");
    check_pos(0, 5'h11, "sw_p0");
    check_pos(1, 5'h09, "sw_p1");

    // Fill every entry
    for (int a = 0; a < 8; a++) begin
      bus_if.i_wr_valid = 1'b1;
      bus_if.i_wr_addr  = 3'(a);
      bus_if.i_wr_data  = 5'h10 | 5'(a);
      tick_n(1);
      model[a] = 5'h10 | 5'(a);
    end
    bus_if.i_wr_valid = 1'b0;
    check_all("fill");

    // Clear sweep with a write held pending and stray shift/clear ignored
    bus_if.i_clear    = 1'b1;
    bus_if.i_wr_valid = 1'b1;
    bus_if.i_wr_addr  = 3'd2;
    bus_if.i_wr_data  = 5'h1F;
    #1;
    chk("clr_req_ready", 32'(bus_if.o_wr_ready), 32'd0);
    chk("clr_req_busy",  32'(bus_if.o_busy),     32'd0);
    tick_n(1);
    for (int c = 0; c < 8; c++) begin
      bus_if.i_clear       = (c == 4);
      bus_if.i_shift_valid = (c == 2);
      bus_if.i_shift_data  = 5'h07;
      #1;
      chk($sformatf("clr_busy_%0d", c),  32'(bus_if.o_busy),     32'd1);
      chk($sformatf("clr_ready_%0d", c), 32'(bus_if.o_wr_ready), 32'd0);
      tick_n(1);
    end
    bus_if.i_clear       = 1'b0;
    bus_if.i_shift_valid = 1'b0;
    #1;
    chk("clr_done_busy",  32'(bus_if.o_busy),     32'd0);
    chk("clr_done_ready", 32'(bus_if.o_wr_ready), 32'd1);
    tick_n(1);
    bus_if.i_wr_valid = 1'b0;
    for (int k = 0; k < 8; k++) model[k] = 5'h00;
    model[2] = 5'h1F;
    check_all("clear");

    // Reset aborts a sweep in its fourth cycle
    bus_if.i_wr_valid = 1'b1;
    bus_if.i_wr_addr  = 3'd6;
    bus_if.i_wr_data  = 5'h16;
    tick_n(1);
    bus_if.i_wr_valid = 1'b0;
    bus_if.i_clear    = 1'b1;
    tick_n(1);
    bus_if.i_clear    = 1'b0;
    tick_n(3);
    rst               = 1'b1;
    bus_if.i_wr_valid = 1'b1;
    bus_if.i_wr_addr  = 3'd1;
    bus_if.i_wr_data  = 5'h1E;
    #1;
    chk("abort_busy_before", 32'(bus_if.o_busy),     32'd1);
    chk("abort_ready_rst",   32'(bus_if.o_wr_ready), 32'd0);
    tick_n(1);
    rst               = 1'b0;
    bus_if.i_wr_valid = 1'b0;
    #1;
    chk("abort_busy_after", 32'(bus_if.o_busy),       32'd0);
    chk("abort_ptr",        32'(bus_if.o_cs_pointer), 32'd0);
    chk("abort_tick",       32'(bus_if.o_scan_tick),  32'd0);
    chk("abort_dig",        32'(bus_if.o_dig_ctrl),   32'h00);
    chk("abort_ready_idle", 32'(bus_if.o_wr_ready),   32'd1);
    for (int k = 0; k < 8; k++) model[k] = 5'h00;
    check_pos(1, 5'h00, "abort_p1");
    check_pos(6, 5'h00, "abort_p6");

    // Blink behaviour (always dark-free when the feature is not built)
    blink_run(8'h01, "blink01");
    blink_run(8'h0C, "blink0C");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
